// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // One bit wider than the index so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: synchronous write port, registered read port that holds when idle.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, occupancy count, status flags and reject pulses.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic                       full,
    output logic                       empty,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc;
    logic          rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A write into a full FIFO is fine when a read frees the same slot this edge.
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en && !wr_acc;
        underflow_d = rd_en && !rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (dout)
    );

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_TH);
    assign almost_empty = (count_q <= AE_TH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with hand-computed expectations and immediate assertions.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic       full;
    logic       empty;
    logic [7:0] dout;
    logic [4:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int vectors     = 0;
    int miscompares = 0;

    sync_fifo #(
        .DATA_WIDTH      (8),
        .DEPTH           (16),
        .ALMOST_FULL_TH  (14),
        .ALMOST_EMPTY_TH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .full         (full),
        .empty        (empty),
        .dout         (dout),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the rising edge.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);

        // Fill with 1..16
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 8'(i));
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_full", 32'(full), (i == 16) ? 1 : 0);
            chk("fill_afull", 32'(almost_full), (i >= 14) ? 1 : 0);
            chk("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
            chk("fill_empty", 32'(empty), 0);
        end
        cyc(0, 1, 0, 8'd99);
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_full", 32'(full), 1);
        cyc(0, 0, 0, 8'h00);
        chk("ovf_clear", 32'(overflow), 0);

        // Drain, expecting 1..16 in order
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk("drain_dout", 32'(dout), 32'(i));
            chk("drain_count", 32'(count), 32'(16 - i));
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(0, 0, 1, 8'h00);
        chk("udf_pulse", 32'(underflow), 1);
        chk("udf_dout_hold", 32'(dout), 16);
        cyc(0, 0, 0, 8'h00);
        chk("udf_clear", 32'(underflow), 0);

        // Wrap: pointers cross index 15 -> 0 during the A0..A9 pass
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk("wrap1_dout", 32'(dout), 32'(8'h10 + i));
        end
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'(8'hA0 + i));
        chk("wrap_count", 32'(count), 10);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk("wrap2_dout", 32'(dout), 32'(8'hA0 + i));
        end
        chk("wrap_empty", 32'(empty), 1);

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h50 + i));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 8'(8'h60 + i));
            chk("simul_dout", 32'(dout), 32'(8'h50 + i));
            chk("simul_count", 32'(count), 5);
        end
        cyc(0, 0, 1, 8'h00);
        chk("simul_tail0", 32'(dout), 32'h54);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk("simul_tail", 32'(dout), 32'(8'h60 + i));
        end
        chk("simul_empty", 32'(empty), 1);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'(8'hC0 + i));
        chk("full_before", 32'(full), 1);
        cyc(0, 1, 1, 8'hEE);
        chk("full_rw_full", 32'(full), 1);
        chk("full_rw_ovf", 32'(overflow), 0);
        chk("full_rw_count", 32'(count), 16);
        chk("full_rw_dout", 32'(dout), 32'hC0);
        for (int i = 1; i < 16; i++) begin
            cyc(0, 0, 1, 8'h00);
            chk("full_drain", 32'(dout), 32'(8'hC0 + i));
        end
        cyc(0, 0, 1, 8'h00);
        chk("full_drain_last", 32'(dout), 32'hEE);
        chk("full_drain_empty", 32'(empty), 1);

        // Simultaneous read/write while empty: write only
        cyc(0, 1, 1, 8'h77);
        chk("empty_rw_count", 32'(count), 1);
        chk("empty_rw_udf", 32'(underflow), 1);
        chk("empty_rw_dout", 32'(dout), 32'hEE);
        chk("empty_rw_empty", 32'(empty), 0);
        cyc(0, 0, 1, 8'h00);
        chk("empty_rw_read", 32'(dout), 32'h77);
        chk("empty_rw_udf_clr", 32'(underflow), 0);

        // Reset mid-operation with a concurrent write
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'(8'h30 + i));
        chk("mid_count", 32'(count), 7);
        cyc(1, 1, 0, 8'hBB);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_dout", 32'(dout), 0);
        cyc(0, 1, 0, 8'h42);
        chk("post_rst_count", 32'(count), 1);
        cyc(0, 0, 1, 8'h00);
        chk("post_rst_dout", 32'(dout), 32'h42);
        chk("post_rst_empty", 32'(empty), 1);
        cyc(0, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO: buffers DATA_WIDTH-bit words between a producer (wr_en/din) and a consumer (rd_en/dout).
- Provides full/empty status plus auxiliary level, almost and error flags.
- Used as a generic elastic buffer inside one clock domain; registered read data, no fall-through.

Parameters:
- DATA_WIDTH, 8, width of din/dout.
- DEPTH, 16, number of storage entries; must be a power of two, at least 2.
- ALMOST_FULL_TH, DEPTH-2, count at or above which almost_full is asserted.
- ALMOST_EMPTY_TH, 2, count at or below which almost_empty is asserted.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request; din is captured when accepted.
- rd_en  input  1  read request.
- din  input  DATA_WIDTH  write data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- dout  output  DATA_WIDTH  registered read data.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= ALMOST_FULL_TH.
- almost_empty  output  1  count <= ALMOST_EMPTY_TH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, dout=0.
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Memory contents are don't-care.
  - rst takes priority over wr_en/rd_en in the same cycle; a reset mid-operation discards all stored data.
- Pointers: $clog2(DEPTH)+1 bits, where the extra MSB is the wrap bit. Index = low bits.
  - empty when pointers are equal.
  - full when low bits are equal and MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write accepted = wr_en && (!full || rd_en). When accepted: mem[wr_ptr]<=din, wr_ptr++.
- Read accepted = rd_en && !empty. When accepted: dout<=mem[rd_ptr], rd_ptr++.
  - Read latency is one cycle: data appears on dout after the edge that accepts the read.
  - dout holds its value when no read is accepted.
- Simultaneous wr_en and rd_en:
  - Not empty, not full: both accepted, count unchanged.
  - Full: both accepted; the read frees the slot being written, so full stays 1.
  - Empty: write only (no fall-through); underflow pulses, dout holds, empty deasserts next cycle.
- Rejected operations:
  - wr_en while full without rd_en: data dropped, pointer unchanged, overflow=1 for one cycle.
  - rd_en while empty: underflow=1 for one cycle.
- Counting and flags:
  - count += write accepted; count -= read accepted.
  - All flags are registered or derived combinationally from registered pointers/count. Each reflects state after the last edge, with no extra latency.
- Write data is never corrupted by wrap-around. FIFO order is strictly preserved.

Decomposition:
- Package sync_fifo_pkg: default DATA_WIDTH/DEPTH constants and a localparam function for pointer width ($clog2(DEPTH)+1).
- Sub-module sync_fifo_mem:
  - DEPTH x DATA_WIDTH storage array with a synchronous write port (we, waddr, wdata).
  - Registered read port (re, raddr, rdata); rdata holds when re=0 and is cleared by rst.
- Top sync_fifo holds pointers, count and flags.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> empty=1, full=0, count=0, dout=0, almost_empty=1.
- Fill: write 1..16 on consecutive cycles -> full=1 after the 16th write, count=16, almost_full=1 from count 14. A 17th write (value 99) -> overflow pulse, count stays 16.
- Drain: read 16 times -> dout sequence 1..16, each one cycle after its read. empty=1 after the last read. An extra read -> underflow pulse, dout stays 16.
- Wrap: write 10 words, read 10, write 10 more (A0..A9), read 10 -> dout A0..A9 in order, with pointers crossing index 15->0.
- Simultaneous: at count=5 assert wr_en+rd_en for 4 cycles -> count stays 5 and dout returns the oldest entries. When full, wr_en+rd_en -> full stays 1 with no overflow. When empty, wr_en+rd_en -> count=1 and underflow pulses.
- Reset mid-operation: after 7 writes assert rst for one cycle with wr_en=1 -> count=0, empty=1, that write is ignored, and a subsequent read sees only data written after reset.
